// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: glyph width, the dark
// glyph and the hex-to-segment table. All patterns are active-high {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam int GLYPH_W = 7;

   // Glyph with every segment off (active-high view).
   localparam logic [GLYPH_W-1:0] SEG_OFF = 7'b000_0000;

   // Hex digit glyphs, indexed by nibble value.
   localparam logic [GLYPH_W-1:0] HEX_GLYPH [16] = '{
      7'b0111111, // 0
      7'b0000110, // 1
      7'b1011011, // 2
      7'b1001111, // 3
      7'b1100110, // 4
      7'b1101101, // 5
      7'b1111101, // 6
      7'b0000111, // 7
      7'b1111111, // 8
      7'b1101111, // 9
      7'b1110111, // A
      7'b1111100, // b
      7'b0111001, // C
      7'b1011110, // d
      7'b1111001, // E
      7'b1110001  // F
   };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to 7-segment decoder, active-high {g..a}.
module hex7seg_dec
   import seg_pkg::*;
(
   input  logic [3:0]         nibble,
   output logic [GLYPH_W-1:0] glyph
);

   // Straight table lookup; every nibble value has a defined glyph.
   always_comb begin
      glyph = HEX_GLYPH[nibble];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller. One digit slot lasts
// REFRESH_DIV clocks; the first GUARD clocks of each slot keep every anode
// off so the previous digit's segments never ghost onto the new anode.
// Slot content is captured once per slot, so mid-slot input changes are
// invisible until the next time that digit comes round.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 16,
   parameter int BLINK_DIV   = 25000000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [4*NUM_DIGITS-1:0]       digits,
   input  logic [NUM_DIGITS-1:0]         raw_en,
   input  logic [GLYPH_W*NUM_DIGITS-1:0] raw_seg,
   input  logic [NUM_DIGITS-1:0]         dp_en,
   input  logic [NUM_DIGITS-1:0]         blank,
   input  logic [NUM_DIGITS-1:0]         blink_en,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [GLYPH_W-1:0]            seg,
   output logic                          dp,
   output logic                          scan_tick,
   output logic                          blink_phase
);

   localparam int PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic POL   = (ACTIVE_LOW != 0);

   // Inactive level of each output pin group, in pin polarity.
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{POL}};
   localparam logic [GLYPH_W-1:0]    SEG_IDLE = {GLYPH_W{POL}};

   logic [PRE_W-1:0]      pre_cnt_q,   pre_cnt_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic                  scan_tick_q, scan_tick_d;
   logic [GLYPH_W-1:0]    glyph_q,     glyph_d;
   logic                  dp_bit_q,    dp_bit_d;
   logic                  dark_q,      dark_d;
   logic [NUM_DIGITS-1:0] an_q,        an_d;
   logic [GLYPH_W-1:0]    seg_q,       seg_d;
   logic                  dp_q,        dp_d;

   logic [3:0]            sel_nibble;
   logic [GLYPH_W-1:0]    sel_raw;
   logic                  sel_raw_en, sel_dp_en, sel_blank, sel_blink_en;
   logic [GLYPH_W-1:0]    dec_glyph;
   logic                  pre_wrap, blink_wrap, capture;
   logic [NUM_DIGITS-1:0] an_act;

   hex7seg_dec u_dec (
      .nibble (sel_nibble),
      .glyph  (dec_glyph)
   );

   // Select the per-digit inputs belonging to the slot currently scanned.
   always_comb begin
      sel_nibble   = 4'h0;
      sel_raw      = SEG_OFF;
      sel_raw_en   = 1'b0;
      sel_dp_en    = 1'b0;
      sel_blank    = 1'b0;
      sel_blink_en = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_nibble   = digits[4*i +: 4];
            sel_raw      = raw_seg[GLYPH_W*i +: GLYPH_W];
            sel_raw_en   = raw_en[i];
            sel_dp_en    = dp_en[i];
            sel_blank    = blank[i];
            sel_blink_en = blink_en[i];
         end
      end
   end

   // Counters, slot capture and next output values.
   always_comb begin
      pre_wrap      = (pre_cnt_q == PRE_W'(REFRESH_DIV - 1));
      blink_wrap    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
      capture       = (pre_cnt_q == '0);

      pre_cnt_d     = pre_wrap ? '0 : pre_cnt_q + PRE_W'(1);
      idx_d         = idx_q;
      if (pre_wrap) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      scan_tick_d   = pre_wrap;

      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

      // Raw pattern wins over the decoded nibble; blank wins over blink.
      glyph_d  = glyph_q;
      dp_bit_d = dp_bit_q;
      dark_d   = dark_q;
      if (capture) begin
         glyph_d  = sel_raw_en ? sel_raw : dec_glyph;
         dp_bit_d = sel_dp_en;
         dark_d   = sel_blank | (sel_blink_en & blink_phase_q);
      end

      // The output registers see the freshly captured content in the
      // capture cycle itself, so a zero guard still shows the right glyph.
      an_act = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_act[i] = (idx_q == IDX_W'(i)) && (pre_cnt_q >= PRE_W'(GUARD)) && !dark_d;
      end
      an_d  = an_act ^ AN_IDLE;
      seg_d = (dark_d ? SEG_OFF : glyph_d) ^ SEG_IDLE;
      dp_d  = (!dark_d && dp_bit_d) ^ POL;
   end

   // State and output registers; reset forces every pin inactive at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q     <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         scan_tick_q   <= 1'b0;
         glyph_q       <= SEG_OFF;
         dp_bit_q      <= 1'b0;
         dark_q        <= 1'b1;
         an_q          <= AN_IDLE;
         seg_q         <= SEG_IDLE;
         dp_q          <= POL;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         scan_tick_q   <= scan_tick_d;
         glyph_q       <= glyph_d;
         dp_bit_q      <= dp_bit_d;
         dark_q        <= dark_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign scan_tick   = scan_tick_q;
   assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a slot scoreboard: each capture
// pushes the expected slot content, which is popped when the output
// registers start showing that slot.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int R     = 8;
   localparam int G     = 2;
   localparam int B     = 64;

   typedef struct packed {
      logic [1:0] idx;
      logic [6:0] glyph;
      logic       dpb;
      logic       dark;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  raw_en;
   logic [27:0] raw_seg;
   logic [3:0]  dp_en;
   logic [3:0]  blank;
   logic [3:0]  blink_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        scan_tick;
   logic        blink_phase;

   logic [6:0]  hex_tab [16];

   slot_t       sb [$];
   slot_t       cur;
   int          m_pre, m_idx, m_bc, pre_prev, cyc;
   logic        m_phase, cap_prev, tick_exp;
   int          n_cmp = 0;
   int          n_err = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (R),
      .GUARD       (G),
      .BLINK_DIV   (B),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digits      (digits),
      .raw_en      (raw_en),
      .raw_seg     (raw_seg),
      .dp_en       (dp_en),
      .blank       (blank),
      .blink_en    (blink_en),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .scan_tick   (scan_tick),
      .blink_phase (blink_phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pre    = 0;
      m_idx    = 0;
      m_bc     = 0;
      m_phase  = 1'b0;
      pre_prev = 0;
      cap_prev = 1'b0;
      tick_exp = 1'b0;
      cur      = '{idx: 2'd0, glyph: 7'h00, dpb: 1'b0, dark: 1'b1};
      sb.delete();
   endtask

   // One clock cycle; entered and left at a falling edge.
   task automatic tick();
      slot_t      nxt;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      if (cap_prev) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty cyc=%0d: observed 0 entries expected 1", cyc);
         end else begin
            cur = sb.pop_front();
         end
      end
      exp_an  = (pre_prev >= G && !cur.dark) ? ~(4'b0001 << cur.idx) : 4'hF;
      exp_seg = cur.dark ? 7'h7F : ~cur.glyph;
      exp_dp  = cur.dark ? 1'b1 : ~cur.dpb;
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("scan_tick", 32'(scan_tick), 32'(tick_exp));
      check("blink_phase", 32'(blink_phase), 32'(m_phase));
      check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      if (m_pre == 0) begin
         nxt.idx   = 2'(m_idx);
         nxt.glyph = raw_en[m_idx] ? raw_seg[7*m_idx +: 7] : hex_tab[digits[4*m_idx +: 4]];
         nxt.dpb   = dp_en[m_idx];
         nxt.dark  = blank[m_idx] | (blink_en[m_idx] & m_phase);
         sb.push_back(nxt);
      end
      cap_prev = (m_pre == 0);
      pre_prev = m_pre;
      tick_exp = (m_pre == R - 1);
      if (m_pre == R - 1) begin
         m_pre = 0;
         m_idx = (m_idx + 1) % N;
      end else begin
         m_pre++;
      end
      if (m_bc == B - 1) begin
         m_bc    = 0;
         m_phase = ~m_phase;
      end else begin
         m_bc++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance until the model reaches the given slot position, bounded.
   task automatic run_until(input int idx, input int pre);
      int budget;
      budget = 0;
      while (!(m_idx == idx && m_pre == pre) && budget < 100) begin
         tick();
         budget++;
      end
      check("wait_bound", 32'(m_idx == idx && m_pre == pre), 32'd1);
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
      check({tag, "_dp"}, 32'(dp), 32'd1);
      check({tag, "_tick"}, 32'(scan_tick), 32'd0);
      check({tag, "_phase"}, 32'(blink_phase), 32'd0);
   endtask

   initial begin
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      cyc      = 0;
      rst      = 1'b1;
      digits   = 16'h1234;
      raw_en   = 4'b0000;
      raw_seg  = '0;
      dp_en    = 4'b0000;
      blank    = 4'b0000;
      blink_en = 4'b0000;
      model_reset();

      // Held in reset across two rising edges.
      @(posedge clk);
      @(negedge clk);
      check_reset_pins("reset_hold");
      @(posedge clk);
      @(negedge clk);
      check_reset_pins("reset_hold2");

      // Plain hex scanning of 1234: two full scan rounds.
      rst = 1'b0;
      run(64);

      // Decimal point on digit 1, digit 3 blanked.
      digits = 16'hABCD;
      dp_en  = 4'b0010;
      blank  = 4'b1000;
      run(40);

      // Blink on digit 0 across several blink half-periods.
      dp_en    = 4'b0000;
      blank    = 4'b0000;
      digits   = 16'h0008;
      blink_en = 4'b0001;
      run(160);

      // Raw "H" on digit 2 overrides nibble 5; blink also with blank on digit 0.
      blink_en       = 4'b0001;
      blank          = 4'b0001;
      raw_en         = 4'b0100;
      raw_seg[20:14] = 7'h76;
      digits         = 16'h0500;
      run(40);

      // Mid-slot nibble change is held off until the next slot-0 capture.
      blink_en = 4'b0000;
      blank    = 4'b0000;
      raw_en   = 4'b0000;
      digits   = 16'h1231;
      run_until(0, 4);
      digits   = 16'h1237;
      run(40);

      // Asynchronous reset in the middle of slot 2.
      run_until(2, 5);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_an", 32'(an), 32'hF);
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_dp", 32'(dp), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check_reset_pins("reset_mid");
      rst = 1'b0;
      model_reset();
      run(48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
